// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage with operand forwarding, a single-cycle ALU
// and an iterative shift-add multiplier, all behind one registered result.
//
// Ports
//   Clk, Reset           clock, synchronous active-high reset
//   in_valid / in_ready  operation handshake (accepted when both are 1)
//   RF_A, RF_B, Immed    register-file operands and extended immediate
//   ALU_Bin_sel          0: forwarded B operand, 1: Immed
//   ALU_func             operation code
//   Fwd_A_sel, Fwd_B_sel 00/11 RF, 01 Fwd_EXMEM, 10 Fwd_MEMWB
//   Fwd_EXMEM, Fwd_MEMWB forwarded results
//   stall                downstream cannot take a result
//   out_valid, ALU_out   registered result and its valid
//   zero, ovf            registered result flags
//   busy                 multiplier iterating
module ex_stage_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] RF_A,
    input  logic [WIDTH-1:0] RF_B,
    input  logic [WIDTH-1:0] Immed,
    input  logic             ALU_Bin_sel,
    input  logic [3:0]       ALU_func,
    input  logic [1:0]       Fwd_A_sel,
    input  logic [1:0]       Fwd_B_sel,
    input  logic [WIDTH-1:0] Fwd_EXMEM,
    input  logic [WIDTH-1:0] Fwd_MEMWB,
    input  logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALU_out,
    output logic             zero,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1010;
    localparam logic [3:0] OP_ROL  = 4'b1100;
    localparam logic [3:0] OP_ROR  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2*WIDTH-1:0]  mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [2*WIDTH-1:0]  prod_q;
    logic [WIDTH-1:0]    alu_out_q;
    logic                zero_q;
    logic                ovf_q;
    logic                out_valid_q;

    logic [WIDTH-1:0]        op_a;
    logic signed [WIDTH-1:0] op_a_s;
    logic [WIDTH-1:0]        op_b_fwd;
    logic [WIDTH-1:0]        op_b;
    logic [WIDTH-1:0]        res_d;
    logic                    ovf_d;
    logic [2*WIDTH-1:0]      prod_d;
    logic [2*WIDTH-1:0]      mul_res;
    logic                    hold;
    logic                    accept;
    logic                    mul_done;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // A-B overflows when the operands differ in sign and the result
    // takes the sign of B.
    function automatic logic sub_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    always_comb begin
        case (Fwd_A_sel)
            2'b01:   op_a = Fwd_EXMEM;
            2'b10:   op_a = Fwd_MEMWB;
            default: op_a = RF_A;
        endcase
        case (Fwd_B_sel)
            2'b01:   op_b_fwd = Fwd_EXMEM;
            2'b10:   op_b_fwd = Fwd_MEMWB;
            default: op_b_fwd = RF_B;
        endcase
        op_b = ALU_Bin_sel ? Immed : op_b_fwd;
    end

    assign op_a_s = op_a;

    // Single-cycle ALU; mul and unused codes yield 0 here.
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (ALU_func)
            OP_ADD: begin
                res_d = op_a + op_b;
                ovf_d = add_ovf(op_a, op_b, res_d);
            end
            OP_SUB: begin
                res_d = op_a - op_b;
                ovf_d = sub_ovf(op_a, op_b, res_d);
            end
            OP_AND:  res_d = op_a & op_b;
            OP_OR:   res_d = op_a | op_b;
            OP_NOT:  res_d = ~op_a;
            OP_NAND: res_d = ~(op_a & op_b);
            OP_NOR:  res_d = ~(op_a | op_b);
            OP_SRA:  res_d = op_a_s >>> 1;
            OP_SRL:  res_d = op_a >> 1;
            OP_SLL:  res_d = op_a << 1;
            OP_ROL:  res_d = {op_a[WIDTH-2:0], op_a[WIDTH-1]};
            OP_ROR:  res_d = {op_a[0], op_a[WIDTH-1:1]};
            default: res_d = '0;
        endcase
    end

    // One shift-add step per cycle. Once the counter is exhausted the
    // accumulated product is final and is simply held until it can load.
    assign prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign mul_res  = (cnt_q != '0) ? prod_d : prod_q;

    assign hold     = out_valid_q && stall;
    assign in_ready = (state_q == S_IDLE) && !hold && !Reset;
    assign accept   = in_valid && in_ready;
    assign mul_done = (state_q == S_MUL) && (cnt_q <= CW'(1)) && !hold;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_out_q   <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && (ALU_func == OP_MUL)) begin
                        state_q     <= S_MUL;
                        cnt_q       <= CW'(WIDTH);
                        mcand_q     <= {{WIDTH{1'b0}}, op_a};
                        mplier_q    <= op_b;
                        prod_q      <= '0;
                        out_valid_q <= 1'b0;
                    end else if (accept) begin
                        alu_out_q   <= res_d;
                        zero_q      <= (res_d == '0);
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                    end else if (!hold) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (cnt_q != '0) begin
                        prod_q   <= prod_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - CW'(1);
                    end
                    if (mul_done) begin
                        state_q     <= S_IDLE;
                        alu_out_q   <= mul_res[WIDTH-1:0];
                        zero_q      <= (mul_res[WIDTH-1:0] == '0);
                        ovf_q       <= |mul_res[2*WIDTH-1:WIDTH];
                        out_valid_q <= 1'b1;
                    end else if (!hold) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ALU_out   = alu_out_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == S_MUL);

endmodule

// File: tb/tb_ex_stage_pipe.sv
module tb_ex_stage_pipe;

    localparam int W  = 32;
    localparam int W8 = 8;
    localparam logic [3:0] OP_MUL = 4'd14;

    logic        Clk = 1'b0;
    logic        Reset, in_valid, ALU_Bin_sel, stall;
    logic [31:0] RF_A, RF_B, Immed, Fwd_EXMEM, Fwd_MEMWB;
    logic [3:0]  ALU_func;
    logic [1:0]  Fwd_A_sel, Fwd_B_sel;

    logic        in_ready, out_valid, zero, ovf, busy;
    logic [31:0] ALU_out;
    logic        in_ready_8, out_valid_8, zero_8, ovf_8, busy_8;
    logic [7:0]  ALU_out_8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    ex_stage_pipe #(.WIDTH(W)) u_dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .Fwd_A_sel(Fwd_A_sel), .Fwd_B_sel(Fwd_B_sel),
        .Fwd_EXMEM(Fwd_EXMEM), .Fwd_MEMWB(Fwd_MEMWB), .stall(stall),
        .out_valid(out_valid), .ALU_out(ALU_out), .zero(zero), .ovf(ovf),
        .busy(busy)
    );

    ex_stage_pipe #(.WIDTH(W8)) u_dut8 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_8),
        .RF_A(RF_A[7:0]), .RF_B(RF_B[7:0]), .Immed(Immed[7:0]),
        .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func),
        .Fwd_A_sel(Fwd_A_sel), .Fwd_B_sel(Fwd_B_sel),
        .Fwd_EXMEM(Fwd_EXMEM[7:0]), .Fwd_MEMWB(Fwd_MEMWB[7:0]), .stall(stall),
        .out_valid(out_valid_8), .ALU_out(ALU_out_8), .zero(zero_8),
        .ovf(ovf_8), .busy(busy_8)
    );

    task automatic check_eq(input string tag, input longint unsigned obs,
                            input longint unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference ALU written from the operation table using plain integer math.
    function automatic void ref_alu(input int w, input logic [3:0] f,
                                    input longint unsigned a_in,
                                    input longint unsigned b_in,
                                    output longint unsigned r, output bit v);
        longint unsigned m, top, a, b, p;
        bit sa, sb, sr;
        m   = (64'd1 << w) - 64'd1;
        top = 64'd1 << (w - 1);
        a   = a_in & m;
        b   = b_in & m;
        sa  = (a & top) != 0;
        sb  = (b & top) != 0;
        r   = 0;
        v   = 1'b0;
        case (f)
            4'd0: begin
                r = (a + b) & m; sr = (r & top) != 0;
                v = (sa == sb) && (sr != sa);
            end
            4'd1: begin
                r = (a - b) & m; sr = (r & top) != 0;
                v = (sa != sb) && (sr != sa);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = ~a & m;
            4'd5:  r = ~(a & b) & m;
            4'd6:  r = ~(a | b) & m;
            4'd8:  r = (a >> 1) | (a & top);
            4'd9:  r = a >> 1;
            4'd10: r = (a << 1) & m;
            4'd12: r = ((a << 1) | (a >> (w - 1))) & m;
            4'd13: r = (a >> 1) | ((a & 64'd1) << (w - 1));
            4'd14: begin
                p = a * b; r = p & m; v = (p >> w) != 0;
            end
            default: r = 0;
        endcase
    endfunction

    function automatic longint unsigned pick(input logic [1:0] sel,
                                             input logic [31:0] rf);
        case (sel)
            2'b01:   return Fwd_EXMEM;
            2'b10:   return Fwd_MEMWB;
            default: return rf;
        endcase
    endfunction

    function automatic longint unsigned opnd_a();
        return pick(Fwd_A_sel, RF_A);
    endfunction

    function automatic longint unsigned opnd_b();
        return ALU_Bin_sel ? Immed : pick(Fwd_B_sel, RF_B);
    endfunction

    task automatic scramble();
        RF_A        = $urandom;
        RF_B        = ($urandom_range(0, 3) == 0) ? RF_A : $urandom;
        Immed       = $urandom;
        Fwd_EXMEM   = $urandom;
        Fwd_MEMWB   = $urandom;
        ALU_Bin_sel = 1'($urandom_range(0, 1));
        Fwd_A_sel   = 2'($urandom_range(0, 3));
        Fwd_B_sel   = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 5) == 0) RF_A = 32'h7FFF_FFFF;
        if ($urandom_range(0, 5) == 0) RF_A = 32'h8000_0000;
    endtask

    task automatic check_res32(input string tag, input longint unsigned r,
                               input bit v);
        check_eq({tag, "_vld"}, out_valid, 1);
        check_eq({tag, "_out"}, ALU_out, r);
        check_eq({tag, "_zero"}, zero, (r == 0));
        check_eq({tag, "_ovf"}, ovf, v);
    endtask

    task automatic check_res8(input string tag, input longint unsigned r,
                              input bit v);
        check_eq({tag, "_vld8"}, out_valid_8, 1);
        check_eq({tag, "_out8"}, ALU_out_8, r);
        check_eq({tag, "_zero8"}, zero_8, (r == 0));
        check_eq({tag, "_ovf8"}, ovf_8, v);
    endtask

    // Issue one operation using the operand inputs already driven, check its
    // result latency and value on both widths, then optionally stall on it.
    task automatic do_op(input string tag, input logic [3:0] f,
                         input int stall_cyc);
        longint unsigned a, b, r, r8;
        bit v, v8;
        int t;
        a = opnd_a();
        b = opnd_b();
        ref_alu(W, f, a, b, r, v);
        ref_alu(W8, f, a, b, r8, v8);
        ALU_func = f;
        stall    = 1'b0;
        #1;
        t = 0;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        check_eq({tag, "_ready"}, in_ready, 1);
        check_eq({tag, "_ready8"}, in_ready_8, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        if (f == OP_MUL) begin
            for (int i = 0; i < W; i++) begin
                check_eq({tag, "_busy_rdy_vld"}, {busy, in_ready, out_valid}, 3'b100);
                check_eq({tag, "_busy8"}, busy_8, (i < W8));
                if (i == W8) check_res8(tag, r8, v8);
                tick();
            end
            check_eq({tag, "_busy_end"}, busy, 0);
            check_res32(tag, r, v);
        end else begin
            check_eq({tag, "_busy"}, busy, 0);
            check_res32(tag, r, v);
            check_res8(tag, r8, v8);
        end
        if (stall_cyc > 0) begin
            stall = 1'b1;
            #1;
            for (int k = 0; k < stall_cyc; k++) begin
                check_eq({tag, "_stall_rdy"}, in_ready, 0);
                tick();
                check_res32({tag, "_held"}, r, v);
                check_eq({tag, "_held_vld8"}, out_valid_8, (f != OP_MUL));
            end
            stall = 1'b0;
        end
        tick();
        check_eq({tag, "_drop"}, out_valid, 0);
        check_eq({tag, "_drop8"}, out_valid_8, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        longint unsigned r1, r2, r8;
        bit v1, v8;
        bit saw_vld;

        Reset    = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        ALU_func = 4'd0;
        scramble();
        tick();
        tick();
        check_eq("rst_out", ALU_out, 0);
        check_eq("rst_flags", {zero, ovf, out_valid, busy}, 4'b0000);
        check_eq("rst_flags8", {zero_8, ovf_8, out_valid_8, busy_8}, 4'b0000);
        check_eq("rst_ready", in_ready, 0);
        Reset = 1'b0;
        #1;
        check_eq("post_rst_ready", in_ready, 1);

        // signed overflow on add
        RF_A = 32'h7FFF_FFFF; RF_B = 32'h1; ALU_Bin_sel = 1'b0;
        Fwd_A_sel = 2'b00; Fwd_B_sel = 2'b00;
        do_op("add_ovf", 4'd0, 0);

        // forwarding plus immediate override, zero result
        Fwd_A_sel = 2'b01; Fwd_EXMEM = 32'd5; ALU_Bin_sel = 1'b1;
        Immed = 32'd5; Fwd_B_sel = 2'b10; Fwd_MEMWB = 32'd77;
        do_op("sub_fwd", 4'd1, 0);

        // multiply whose product lands entirely in the upper half
        RF_A = 32'h0001_0000; RF_B = 32'h0001_0000; ALU_Bin_sel = 1'b0;
        Fwd_A_sel = 2'b00; Fwd_B_sel = 2'b11;
        do_op("mul_hi", OP_MUL, 0);

        // rotate/shift/undefined code corners
        RF_A = 32'h0000_0001; Fwd_A_sel = 2'b00;
        do_op("ror", 4'd13, 0);
        RF_A = 32'h0000_0080; Fwd_A_sel = 2'b11;
        do_op("sra", 4'd8, 1);
        RF_A = 32'h1234_5678; Fwd_A_sel = 2'b00;
        do_op("op15", 4'd15, 0);

        // held result under stall with a new add pending
        scramble(); ALU_func = 4'd0;
        ref_alu(W, 4'd0, opnd_a(), opnd_b(), r1, v1);
        in_valid = 1'b1;
        tick();
        check_eq("stl_first", ALU_out, r1);
        check_eq("stl_first_vld", out_valid, 1);
        scramble();
        ref_alu(W, 4'd0, opnd_a(), opnd_b(), r2, v1);
        ref_alu(W8, 4'd0, opnd_a(), opnd_b(), r8, v8);
        stall = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("stl_rdy", in_ready, 0);
            tick();
            check_eq("stl_hold", ALU_out, r1);
            check_eq("stl_hold_vld", out_valid, 1);
        end
        stall = 1'b0;
        #1;
        check_eq("stl_release_rdy", in_ready, 1);
        tick();
        check_eq("stl_new", ALU_out, r2);
        check_eq("stl_new8", ALU_out_8, r8);
        check_eq("stl_new_vld", out_valid, 1);

        // back-to-back: in_valid stays high for a second operation
        scramble(); ALU_func = 4'd1;
        ref_alu(W, 4'd1, opnd_a(), opnd_b(), r2, v1);
        tick();
        check_eq("b2b_vld", out_valid, 1);
        check_eq("b2b_out", ALU_out, r2);
        check_eq("b2b_ovf", ovf, v1);
        in_valid = 1'b0;
        tick();
        check_eq("b2b_drop", out_valid, 0);

        // reset in the 10th cycle of a multiply aborts it
        scramble(); ALU_func = OP_MUL; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("abort_busy", busy, 1);
        Reset = 1'b1;
        #1;
        check_eq("abort_rdy", {in_ready, in_ready_8}, 2'b00);
        tick();
        Reset = 1'b0;
        check_eq("abort_out", ALU_out, 0);
        check_eq("abort_flags", {zero, ovf, out_valid, busy}, 4'b0000);
        check_eq("abort_out8", ALU_out_8, 0);
        saw_vld = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            saw_vld |= out_valid | busy;
        end
        check_eq("abort_no_pulse", saw_vld, 0);
        check_eq("abort_idle_rdy", in_ready, 1);

        // randomized operations with random stall on the result
        for (int n = 0; n < 40; n++) begin
            scramble();
            do_op("rnd", 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_pipe.md
EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits, legal range 8..64.
REQ-002 Port: Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operation and operands present this cycle.
REQ-005 Port: in_ready  output  1  block accepts an operation this cycle.
REQ-006 Port: RF_A, RF_B  input  WIDTH each  register-file operands.
REQ-007 Port: Immed  input  WIDTH  extended immediate.
REQ-008 Port: ALU_Bin_sel  input  1  0 = forwarded B operand, 1 = Immed.
REQ-009 Port: ALU_func  input  4  operation code.
REQ-010 Port: Fwd_A_sel, Fwd_B_sel  input  2 each  operand source: 00 RF, 01 Fwd_EXMEM, 10 Fwd_MEMWB, 11 RF.
REQ-011 Port: Fwd_EXMEM, Fwd_MEMWB  input  WIDTH each  forwarded results.
REQ-012 Port: stall  input  1  downstream cannot take a result.
REQ-013 Port: out_valid  output  1  registered result valid.
REQ-014 Port: ALU_out  output  WIDTH  registered result.
REQ-015 Port: zero  output  1  registered, 1 when ALU_out == 0.
REQ-016 Port: ovf  output  1  registered overflow flag.
REQ-017 Port: busy  output  1  multiplier iterating.

Function
REQ-018 Operand A SHALL be selected by Fwd_A_sel; operand B SHALL be selected by Fwd_B_sel, then replaced by Immed when ALU_Bin_sel = 1, irrespective of Fwd_B_sel.
REQ-019 Operation encoding SHALL be: 0000 add, 0001 sub (A-B), 0010 and, 0011 or, 0100 not A, 0101 nand, 0110 nor, 1000 sra A by 1, 1001 srl A by 1, 1010 sll A by 1, 1100 rol A by 1, 1101 ror A by 1, 1110 mul (unsigned, low WIDTH bits); all other codes produce 0.
REQ-020 An operation SHALL be accepted on a rising edge where in_valid = 1 and in_ready = 1; operands SHALL be sampled on that edge only.
REQ-021 in_ready SHALL equal 1 only when the state is IDLE and NOT (out_valid = 1 and stall = 1).
REQ-022 State machine SHALL have states IDLE and MUL; IDLE -> MUL on acceptance of code 1110; MUL -> IDLE on completion; all other codes remain in IDLE.
REQ-023 Single-cycle operations SHALL load ALU_out, zero, ovf and set out_valid = 1 on the acceptance edge (latency 1).
REQ-024 mul SHALL use an iterative shift-add datapath, one multiplier bit per cycle, with a cycle counter loaded to WIDTH at acceptance; busy = 1 exactly while the state is MUL.
REQ-025 mul SHALL load its result and set out_valid = 1 on the WIDTH-th edge after acceptance, provided the output register is free at that edge.
REQ-026 When the counter reaches 0 while out_valid = 1 and stall = 1, the block SHALL hold in MUL with the product held until the output register frees.
REQ-027 While out_valid = 1 and stall = 1, ALU_out, zero, ovf and out_valid SHALL hold unchanged.
REQ-028 When out_valid = 1 and stall = 0 and no new result loads at that edge, out_valid SHALL go to 0; back-to-back single-cycle operations SHALL produce out_valid = 1 on consecutive cycles.
REQ-029 ovf SHALL be the two's-complement signed overflow for add and sub, 1 for mul when the upper WIDTH product bits are non-zero, and 0 for all other codes.
REQ-030 Arithmetic SHALL wrap modulo 2^WIDTH; shifts and rotates SHALL move exactly one bit; sra SHALL replicate bit WIDTH-1.

Reset
REQ-031 While Reset = 1 at a rising edge, the block SHALL enter IDLE, clear the counter, and drive ALU_out = 0, zero = 0, ovf = 0, out_valid = 0, busy = 0.
REQ-032 Reset asserted during MUL SHALL abort the multiply with no result delivered; in_ready SHALL be 0 in any cycle where Reset = 1.

Verification
REQ-033 WIDTH=32, add A=0x7FFFFFFF, B=0x00000001 -> next cycle ALU_out=0x80000000, ovf=1, zero=0, out_valid=1.
REQ-034 sub with Fwd_A_sel=01 (Fwd_EXMEM=5), ALU_Bin_sel=1 (Immed=5), Fwd_B_sel=10 -> ALU_out=0, zero=1, ovf=0.
REQ-035 mul A=0x00010000, B=0x00010000 -> busy=1 and in_ready=0 for 32 cycles, then ALU_out=0, zero=1, ovf=1, out_valid=1.
REQ-036 Result valid with stall=1 held 3 cycles, new add presented -> outputs unchanged, in_ready=0, new add accepted on the first edge after stall=0.
REQ-037 Reset pulsed 1 cycle at the 10th cycle of a mul -> all outputs 0, state IDLE, no out_valid pulse for the aborted mul.
REQ-038 WIDTH=8, ror A=0x01 -> ALU_out=0x80; sra A=0x80 -> ALU_out=0xC0; code 1111 -> ALU_out=0x00, zero=1.
